// File: rtl/endgame_banner_pkg.sv
// Shared types, character codes and the fixed message table for the end-of-game banner.
package endgame_banner_pkg;

    localparam int unsigned GLYPH_W   = 5;
    localparam int unsigned GLYPH_H   = 7;
    // Slots per message table entry; shorter messages are padded with blanks.
    localparam int unsigned MSG_SLOTS = 8;

    typedef enum logic [5:0] {
        ChBlank,
        ChA, ChB, ChC, ChD, ChE, ChF, ChG, ChH, ChI, ChJ, ChK, ChL, ChM,
        ChN, ChO, ChP, ChQ, ChR, ChS, ChT, ChU, ChV, ChW, ChX, ChY, ChZ,
        Ch0, Ch1, Ch2, Ch3, Ch4, Ch5, Ch6, Ch7, Ch8, Ch9
    } char_e;

    typedef enum logic [1:0] {
        MsgEnd,
        MsgP1Win,
        MsgP2Win,
        MsgPause
    } msg_e;

    typedef enum logic [1:0] {
        StIdle,
        StReveal,
        StShow
    } state_e;

    // Number of characters in a message, blanks inside the text included.
    function automatic logic [3:0] msg_len(msg_e sel);
        case (sel)
            MsgEnd:   return 4'd3;
            MsgP1Win: return 4'd6;
            MsgP2Win: return 4'd6;
            default:  return 4'd5;
        endcase
    endfunction

    // Character code at position idx of the selected message.
    function automatic char_e msg_char(msg_e sel, int unsigned idx);
        char_e row [MSG_SLOTS];
        case (sel)
            MsgEnd:   row = '{ChE, ChN, ChD, ChBlank, ChBlank, ChBlank, ChBlank, ChBlank};
            MsgP1Win: row = '{ChP, Ch1, ChBlank, ChW, ChI, ChN, ChBlank, ChBlank};
            MsgP2Win: row = '{ChP, Ch2, ChBlank, ChW, ChI, ChN, ChBlank, ChBlank};
            default:  row = '{ChP, ChA, ChU, ChS, ChE, ChBlank, ChBlank, ChBlank};
        endcase
        if (idx >= MSG_SLOTS) begin
            return ChBlank;
        end
        return row[idx[2:0]];
    endfunction

endpackage

// File: rtl/endgame_banner_glyph_rom.sv
// Combinational 5x7 font: (code, row, col) -> pixel bit, row 0 at top, MSB = leftmost column.
module banner_glyph_rom
    import endgame_banner_pkg::*;
(
    input  logic [5:0] code,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pixel
);

    logic [34:0] glyph;
    logic [5:0]  pos;

    // Glyph lookup; each literal lists the seven rows top to bottom.
    always_comb begin
        glyph = '0;
        case (char_e'(code))
            ChA: glyph = 35'b01110_10001_10001_11111_10001_10001_10001;
            ChB: glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
            ChC: glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
            ChD: glyph = 35'b11110_10001_10001_10001_10001_10001_11110;
            ChE: glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
            ChF: glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
            ChG: glyph = 35'b01110_10001_10000_10111_10001_10001_01111;
            ChH: glyph = 35'b10001_10001_10001_11111_10001_10001_10001;
            ChI: glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
            ChJ: glyph = 35'b00111_00010_00010_00010_00010_10010_01100;
            ChK: glyph = 35'b10001_10010_10100_11000_10100_10010_10001;
            ChL: glyph = 35'b10000_10000_10000_10000_10000_10000_11111;
            ChM: glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
            ChN: glyph = 35'b10001_10001_11001_10101_10011_10001_10001;
            ChO: glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
            ChP: glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
            ChQ: glyph = 35'b01110_10001_10001_10001_10101_10010_01101;
            ChR: glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
            ChS: glyph = 35'b01111_10000_10000_01110_00001_00001_11110;
            ChT: glyph = 35'b11111_00100_00100_00100_00100_00100_00100;
            ChU: glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
            ChV: glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
            ChW: glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
            ChX: glyph = 35'b10001_10001_01010_00100_01010_10001_10001;
            ChY: glyph = 35'b10001_10001_01010_00100_00100_00100_00100;
            ChZ: glyph = 35'b11111_00001_00010_00100_01000_10000_11111;
            Ch0: glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
            Ch1: glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
            Ch2: glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
            Ch3: glyph = 35'b11111_00010_00100_00010_00001_10001_01110;
            Ch4: glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
            Ch5: glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
            Ch6: glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
            Ch7: glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
            Ch8: glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
            Ch9: glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
            default: glyph = '0;
        endcase
    end

    // Bit select; out-of-range row/col read dark instead of aliasing into the next row.
    always_comb begin
        pos   = 6'(row) * 6'(GLYPH_W) + 6'(col);
        pixel = 1'b0;
        if ((32'(row) < GLYPH_H) && (32'(col) < GLYPH_W)) begin
            pixel = glyph[6'd34 - pos];
        end
    end

endmodule

// File: rtl/endgame_banner.sv
// Animated end-of-game banner: typewriter reveal, blink, two-stage pixel pipeline.
module endgame_banner
    import endgame_banner_pkg::*;
#(
    parameter int unsigned MAX_CHARS     = 8,
    parameter int unsigned SCALE_LOG2    = 2,
    parameter int unsigned PITCH_LOG2    = 5,
    parameter int unsigned REVEAL_FRAMES = 8,
    parameter int unsigned BLINK_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       clear,
    input  logic [1:0] msg_sel,
    input  logic       frame_tick,
    input  logic [9:0] start_x,
    input  logic [9:0] start_y,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       display,
    output logic       busy,
    output logic       done
);

    localparam int unsigned RevW      = $clog2(MAX_CHARS + 1);
    localparam int unsigned MaxFrames = (BLINK_FRAMES > REVEAL_FRAMES) ? BLINK_FRAMES
                                                                       : REVEAL_FRAMES;
    localparam int unsigned FrameW    = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;
    localparam int unsigned GcolW     = PITCH_LOG2 - SCALE_LOG2;
    localparam int unsigned IdxW      = 11 - PITCH_LOG2;
    localparam logic [10:0] SpanY     = 11'(GLYPH_H << SCALE_LOG2);

    state_e            state_q, state_d;
    msg_e              msg_q, msg_d;
    logic [RevW-1:0]   reveal_cnt_q, reveal_cnt_d;
    logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
    logic              blink_on_q, blink_on_d;
    logic [RevW-1:0]   cur_len;

    // Clamp table length to MAX_CHARS so a narrow build never over-counts the reveal.
    always_comb begin
        cur_len = RevW'(msg_len(msg_q));
        if (32'(msg_len(msg_q)) > MAX_CHARS) begin
            cur_len = RevW'(MAX_CHARS);
        end
    end

    // State register and animation counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            msg_q        <= MsgEnd;
            reveal_cnt_q <= '0;
            frame_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            reveal_cnt_q <= reveal_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_on_q   <= blink_on_d;
        end
    end

    // Next-state: clear beats start, start restarts from any state, ticks advance the animation.
    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        reveal_cnt_d = reveal_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        blink_on_d   = blink_on_q;
        if (clear) begin
            state_d      = StIdle;
            reveal_cnt_d = '0;
            frame_cnt_d  = '0;
            blink_on_d   = 1'b1;
        end else if (start) begin
            state_d      = StReveal;
            msg_d        = msg_e'(msg_sel);
            reveal_cnt_d = '0;
            frame_cnt_d  = '0;
            blink_on_d   = 1'b1;
        end else if (frame_tick) begin
            case (state_q)
                StReveal: begin
                    if (frame_cnt_q == FrameW'(REVEAL_FRAMES - 1)) begin
                        frame_cnt_d  = '0;
                        reveal_cnt_d = reveal_cnt_q + 1'b1;
                        if (reveal_cnt_d == cur_len) begin
                            state_d    = StShow;
                            blink_on_d = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                StShow: begin
                    if (frame_cnt_q == FrameW'(BLINK_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        blink_on_d  = ~blink_on_q;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = (state_q == StReveal);
        done = (state_q == StShow);
    end

    logic [10:0]      dx, dy, span_x;
    logic             in_region_d, in_region_q;
    logic             col_ok_d, col_ok_q;
    logic [IdxW-1:0]  char_idx_d, char_idx_q;
    logic [GcolW-1:0] gcol_d, gcol_q;
    logic [2:0]       grow_d, grow_q;
    logic             display_d;
    logic             rom_bit;
    char_e            char_code;

    // Stage 1 geometry: 11-bit offsets, and the x>=/y>= terms keep off-screen overhang from wrapping.
    always_comb begin
        dx          = {1'b0, x} - {1'b0, start_x};
        dy          = {1'b0, y} - {1'b0, start_y};
        span_x      = 11'(cur_len) << PITCH_LOG2;
        in_region_d = (x >= start_x) && (y >= start_y) && (dx < span_x) && (dy < SpanY);
        char_idx_d  = dx[10:PITCH_LOG2];
        gcol_d      = dx[PITCH_LOG2-1:SCALE_LOG2];
        col_ok_d    = (gcol_d < GcolW'(GLYPH_W));
        grow_d      = dy[SCALE_LOG2 +: 3];
    end

    assign char_code = msg_char(msg_q, 32'(char_idx_q));

    banner_glyph_rom u_glyph_rom (
        .code  (char_code),
        .row   (grow_q),
        .col   (gcol_q[2:0]),
        .pixel (rom_bit)
    );

    // Stage 2 combine: animation state is taken live here rather than carried down the pipe.
    always_comb begin
        display_d = in_region_q && col_ok_q && (32'(char_idx_q) < 32'(reveal_cnt_q)) &&
                    blink_on_q && rom_bit && (state_q != StIdle);
    end

    // Pixel pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_region_q <= 1'b0;
            col_ok_q    <= 1'b0;
            char_idx_q  <= '0;
            gcol_q      <= '0;
            grow_q      <= '0;
            display     <= 1'b0;
        end else begin
            in_region_q <= in_region_d;
            col_ok_q    <= col_ok_d;
            char_idx_q  <= char_idx_d;
            gcol_q      <= gcol_d;
            grow_q      <= grow_d;
            display     <= display_d;
        end
    end

endmodule

// File: tb/tb_endgame_banner.sv
// Directed plus randomized bench for endgame_banner against a tick-counting reference model.
module tb_endgame_banner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] msg_sel = 2'd0;
    logic       frame_tick = 1'b0;
    logic [9:0] start_x = 10'd100;
    logic [9:0] start_y = 10'd200;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       display, busy, done;

    int checks = 0;
    int passed = 0;

    // Reference model: only "is it running", which message, and ticks since start.
    bit    m_active = 1'b0;
    int    m_msg = 0;
    int    m_ticks = 0;
    string m_text [4] = '{"END", "P1 WIN", "P2 WIN", "PAUSE"};

    endgame_banner dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .msg_sel    (msg_sel),
        .frame_tick (frame_tick),
        .start_x    (start_x),
        .start_y    (start_y),
        .x          (x),
        .y          (y),
        .display    (display),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] font(byte c);
        case (c)
            "E": return 35'b11111_10000_10000_11110_10000_10000_11111;
            "N": return 35'b10001_10001_11001_10101_10011_10001_10001;
            "D": return 35'b11110_10001_10001_10001_10001_10001_11110;
            "P": return 35'b11110_10001_10001_11110_10000_10000_10000;
            "W": return 35'b10001_10001_10001_10101_10101_10101_01010;
            "I": return 35'b01110_00100_00100_00100_00100_00100_01110;
            "A": return 35'b01110_10001_10001_11111_10001_10001_10001;
            "U": return 35'b10001_10001_10001_10001_10001_10001_01110;
            "S": return 35'b01111_10000_10000_01110_00001_00001_11110;
            "1": return 35'b00100_01100_00100_00100_00100_00100_01110;
            "2": return 35'b01110_10001_00001_00010_00100_01000_11111;
            default: return '0;
        endcase
    endfunction

    function automatic int m_len();
        return m_text[m_msg].len();
    endfunction

    function automatic int m_reveal();
        return (m_ticks / 8 > m_len()) ? m_len() : m_ticks / 8;
    endfunction

    function automatic bit m_showing();
        return m_active && (m_ticks >= 8 * m_len());
    endfunction

    function automatic bit m_blink();
        if (!m_showing()) return 1'b1;
        return (((m_ticks - 8 * m_len()) / 30) % 2) == 0;
    endfunction

    function automatic bit m_pixel(int px, int py);
        int dx, dy, ci, col, row;
        logic [34:0] g;
        if (!m_active || px < int'(start_x) || py < int'(start_y)) return 1'b0;
        dx = px - int'(start_x);
        dy = py - int'(start_y);
        if (dx >= m_len() * 32 || dy >= 28) return 1'b0;
        ci  = dx / 32;
        col = (dx % 32) / 4;
        row = dy / 4;
        if (col >= 5 || ci >= m_reveal() || !m_blink()) return 1'b0;
        g = font(m_text[m_msg][ci]);
        return g[34 - (row * 5 + col)];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(posedge clk);
            #1 frame_tick = 1'b0;
            if (m_active) m_ticks++;
        end
    endtask

    task automatic do_start(input int sel);
        msg_sel = 2'(sel);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        m_active = 1'b1;
        m_msg    = sel;
        m_ticks  = 0;
    endtask

    // Present a pixel, wait out the two-cycle latency, compare all outputs.
    task automatic probe(input string tag, input int px, input int py);
        x = 10'(px);
        y = 10'(py);
        @(posedge clk);
        @(posedge clk);
        #1;
        check({tag, ".display"}, display, m_pixel(px, py));
        check({tag, ".busy"}, busy, m_active && !m_showing());
        check({tag, ".done"}, done, m_showing());
    endtask

    initial begin
        int sx, sy, px, py;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        probe("reset", 100, 200);

        // END at (100,200): typewriter reveal, glyph geometry, blink.
        do_start(0);
        tick(8);
        check("e_top_exp", m_pixel(100, 200), 1'b1);
        probe("e_top", 100, 200);
        probe("n_hidden", 132, 200);
        tick(8);
        probe("n_shown", 132, 200);
        tick(8);
        probe("end_done", 100, 200);
        probe("gcol4", 116, 200);
        probe("gcol5_gap", 120, 200);
        probe("past_len", 196, 200);
        probe("below_glyph", 100, 228);
        probe("left_of", 99, 200);
        for (int i = 0; i < 12; i++) begin
            probe("end_rand", 100 + int'($urandom_range(0, 100)), 200 + int'($urandom_range(0, 30)));
        end
        tick(30);
        probe("blink_off", 100, 200);
        tick(30);
        probe("blink_on", 100, 200);

        // Clear beats start in the same cycle.
        msg_sel = 2'd1;
        start   = 1'b1;
        clear   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        clear = 1'b0;
        m_active = 1'b0;
        probe("clear_wins", 100, 200);
        tick(40);
        probe("idle_ticks", 100, 200);

        // Reset mid-reveal.
        do_start(1);
        tick(10);
        probe("p1_reveal", 100, 200);
        x = 10'd100;
        y = 10'd200;
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_active = 1'b0;
        check("rst_display", display, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;

        // P2 WIN anchored at x=1000: clipped at the right edge, no wrap to low x.
        start_x = 10'd1000;
        start_y = 10'd100;
        do_start(2);
        tick(48);
        for (int px2 = 1000; px2 < 1024; px2 += 2) probe("clip_hi", px2, 104);
        for (int px2 = 0; px2 < 40; px2 += 4) probe("clip_lo", px2, 104);

        // Randomized anchors, messages and tick counts.
        for (int it = 0; it < 8; it++) begin
            sx = int'($urandom_range(0, 1023));
            sy = int'($urandom_range(0, 1000));
            start_x = 10'(sx);
            start_y = 10'(sy);
            do_start(int'($urandom_range(0, 3)));
            tick(int'($urandom_range(0, 120)));
            for (int k = 0; k < 10; k++) begin
                px = sx + int'($urandom_range(0, 200)) - 4;
                py = sy + int'($urandom_range(0, 30)) - 1;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                if (px > 1023) px = 1023;
                if (py > 1023) py = 1023;
                probe("rand", px, py);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
